// File: rtl/uart_tx_frame_engine.sv
// Purpose : UART transmitter; serialises one DATA_WIDTH-bit word LSB-first as
//           start + data + optional parity + 1/2 stop bits.
// Latency : tx_out drops to the start bit on the accept edge; frame completes
//           after (1+DATA_WIDTH+parity_en+1+stop_2)*(baud_div+1) cycles.
// Backpres: busy is high while a frame is in flight. data_valid is ignored
//           while busy; the requester holds it until busy falls.
//
// Ports:
//   UCLK, reset (async, active-low)
//   tx_data, data_valid          word and request; sampled on the accept edge
//   parity_en, parity_type       parity insert / 0 even, 1 odd
//   stop_2                       0 one stop bit, 1 two stop bits
//   baud_div                     bit period minus one, in UCLK cycles
//   tx_out, busy, tx_done        registered line, frame-active flag, done pulse
module uart_tx_frame_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  UCLK,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  data_valid,
  input  logic                  parity_en,
  input  logic                  parity_type,
  input  logic                  stop_2,
  input  logic [DIV_WIDTH-1:0]  baud_div,
  output logic                  tx_out,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] shreg;     // latched word, shifted right as bits go out
  logic [DIV_WIDTH-1:0]  div_l;     // latched bit period minus one
  logic [DIV_WIDTH-1:0]  bit_cnt;   // position inside the current bit period
  logic [IDX_W-1:0]      idx;       // data bit index
  logic                  par_en_l;
  logic                  par_bit_l; // parity bit precomputed at accept
  logic                  stop2_l;
  logic                  stop_idx;  // which stop bit is on the line
  logic                  wrap;

  // Counter compares against the latched divider, so an all-ones divider
  // wraps exactly at the top value and never overflows.
  assign wrap = (bit_cnt == div_l);

  always_ff @(posedge UCLK or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      shreg     <= '0;
      div_l     <= '0;
      bit_cnt   <= '0;
      idx       <= '0;
      par_en_l  <= 1'b0;
      par_bit_l <= 1'b0;
      stop2_l   <= 1'b0;
      stop_idx  <= 1'b0;
      tx_out    <= 1'b1;
      busy      <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      tx_done <= 1'b0;

      if (state != IDLE) begin
        bit_cnt <= wrap ? '0 : bit_cnt + DIV_WIDTH'(1);
      end

      case (state)
        IDLE: begin
          bit_cnt <= '0;
          tx_out  <= 1'b1;
          if (data_valid) begin
            shreg     <= tx_data;
            div_l     <= baud_div;
            par_en_l  <= parity_en;
            par_bit_l <= (^tx_data) ^ parity_type;
            stop2_l   <= stop_2;
            idx       <= '0;
            stop_idx  <= 1'b0;
            tx_out    <= 1'b0;
            busy      <= 1'b1;
            state     <= START;
          end
        end

        START: begin
          if (wrap) begin
            tx_out <= shreg[0];
            shreg  <= shreg >> 1;
            state  <= DATA;
          end
        end

        DATA: begin
          if (wrap) begin
            if (idx == LAST_IDX) begin
              // index is left at the last value; it is reloaded on accept
              if (par_en_l) begin
                tx_out <= par_bit_l;
                state  <= PARITY;
              end else begin
                tx_out <= 1'b1;
                state  <= STOP;
              end
            end else begin
              idx    <= idx + IDX_W'(1);
              tx_out <= shreg[0];
              shreg  <= shreg >> 1;
            end
          end
        end

        PARITY: begin
          if (wrap) begin
            tx_out <= 1'b1;
            state  <= STOP;
          end
        end

        STOP: begin
          if (wrap) begin
            if (stop_idx == stop2_l) begin
              tx_out  <= 1'b1;
              busy    <= 1'b0;
              tx_done <= 1'b1;
              state   <= IDLE;
            end else begin
              stop_idx <= 1'b1;
            end
          end
        end

        default: begin
          tx_out <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame_engine.sv
module tb_uart_tx_frame_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic pen, ptype, s2;

  // 8-bit build, 16-bit divider
  logic [7:0]  d8;
  logic        v8;
  logic [15:0] div8;
  logic        tx8, busy8, done8;
  // 5-bit build, 4-bit divider (all-ones divider reachable in few cycles)
  logic [4:0]  d5;
  logic        v5;
  logic [3:0]  div5;
  logic        tx5, busy5, done5;
  // 9-bit build
  logic [8:0]  d9;
  logic        v9;
  logic [15:0] div9;
  logic        tx9, busy9, done9;

  uart_tx_frame_engine #(.DATA_WIDTH(8), .DIV_WIDTH(16)) dut8 (
    .UCLK(clk), .reset(rst_n), .tx_data(d8), .data_valid(v8),
    .parity_en(pen), .parity_type(ptype), .stop_2(s2), .baud_div(div8),
    .tx_out(tx8), .busy(busy8), .tx_done(done8)
  );
  uart_tx_frame_engine #(.DATA_WIDTH(5), .DIV_WIDTH(4)) dut5 (
    .UCLK(clk), .reset(rst_n), .tx_data(d5), .data_valid(v5),
    .parity_en(pen), .parity_type(ptype), .stop_2(s2), .baud_div(div5),
    .tx_out(tx5), .busy(busy5), .tx_done(done5)
  );
  uart_tx_frame_engine #(.DATA_WIDTH(9), .DIV_WIDTH(16)) dut9 (
    .UCLK(clk), .reset(rst_n), .tx_data(d9), .data_valid(v9),
    .parity_en(pen), .parity_type(ptype), .stop_2(s2), .baud_div(div9),
    .tx_out(tx9), .busy(busy9), .tx_done(done9)
  );

  int   sel = 8;
  logic stx, sbusy, sdone;
  always_comb begin
    stx = tx8; sbusy = busy8; sdone = done8;
    case (sel)
      5: begin stx = tx5; sbusy = busy5; sdone = done5; end
      9: begin stx = tx9; sbusy = busy9; sdone = done9; end
      default: ;
    endcase
  end

  int checks = 0;
  int failures = 0;
  int done8_cnt = 0;
  logic exp_q[$];   // expected tx_out value per cycle of the frame

  always @(negedge clk) if (done8 === 1'b1) done8_cnt++;

  task automatic push_bit(input logic b, input int div);
    for (int c = 0; c <= div; c++) exp_q.push_back(b);
  endtask

  // Reference frame: start, data LSB-first, parity, stop bits.
  task automatic push_frame(input logic [8:0] data, input int width, input logic p_en,
                            input logic p_ty, input logic st2, input int div);
    logic par;
    par = p_ty;
    push_bit(1'b0, div);
    for (int i = 0; i < width; i++) begin
      par = par ^ data[i];
      push_bit(data[i], div);
    end
    if (p_en) push_bit(par, div);
    push_bit(1'b1, div);
    if (st2) push_bit(1'b1, div);
  endtask

  task automatic test_reset;
    rst_n = 1'b1; v8 = 0; v5 = 0; v9 = 0;
    d8 = '0; d5 = '0; d9 = '0; div8 = '0; div5 = '0; div9 = '0;
    pen = 0; ptype = 0; s2 = 0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({tx8, busy8, done8, tx5, busy5, done5, tx9, busy9, done9} !== 9'b100_100_100) begin
      failures++;
      $display("FAIL reset_state got=%b exp=100100100",
               {tx8, busy8, done8, tx5, busy5, done5, tx9, busy9, done9});
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); @(negedge clk);
    checks++;
    if ({tx8, busy8, done8} !== 3'b100) begin
      failures++;
      $display("FAIL idle_after_reset got=%b exp=100", {tx8, busy8, done8});
    end
  endtask

  task automatic test_8n1;
    logic e;
    int cyc;
    sel = 8; exp_q.delete();
    @(negedge clk);
    d8 = 8'hA5; pen = 0; ptype = 0; s2 = 0; div8 = 0; v8 = 1;
    push_frame(9'h0A5, 8, 1'b0, 1'b0, 1'b0, 0);
    @(negedge clk); v8 = 0;
    cyc = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({stx, sbusy, sdone} !== {e, 2'b10}) begin
        failures++;
        $display("FAIL 8n1 cyc=%0d got(tx,busy,done)=%b exp=%b", cyc, {stx, sbusy, sdone}, {e, 2'b10});
      end
      cyc++;
      @(negedge clk);
    end
    checks++;
    if ({stx, sbusy, sdone} !== 3'b101) begin
      failures++;
      $display("FAIL 8n1_done cyc=%0d got=%b exp=101", cyc, {stx, sbusy, sdone});
    end
    @(negedge clk);
    checks++;
    if (sdone !== 1'b0) begin
      failures++;
      $display("FAIL 8n1_done_pulse got=%b exp=0", sdone);
    end
  endtask

  task automatic test_parity;
    logic [7:0] dv [3] = '{8'hA5, 8'hA5, 8'h07};
    logic       ty [3] = '{1'b0, 1'b1, 1'b0};
    logic       st [3] = '{1'b0, 1'b1, 1'b0};
    logic e;
    int cyc;
    sel = 8;
    for (int k = 0; k < 3; k++) begin
      exp_q.delete();
      @(negedge clk);
      d8 = dv[k]; pen = 1; ptype = ty[k]; s2 = st[k]; div8 = 0; v8 = 1;
      push_frame({1'b0, dv[k]}, 8, 1'b1, ty[k], st[k], 0);
      @(negedge clk); v8 = 0; pen = 0; ptype = ~ptype; s2 = ~s2;
      cyc = 0;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({stx, sbusy, sdone} !== {e, 2'b10}) begin
          failures++;
          $display("FAIL parity k=%0d cyc=%0d got=%b exp=%b", k, cyc, {stx, sbusy, sdone}, {e, 2'b10});
        end
        cyc++;
        @(negedge clk);
      end
      checks++;
      if ({stx, sbusy, sdone} !== 3'b101) begin
        failures++;
        $display("FAIL parity_done k=%0d cyc=%0d got=%b exp=101", k, cyc, {stx, sbusy, sdone});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_divider;
    logic e;
    int cyc, busy_cyc;
    sel = 8; exp_q.delete();
    @(negedge clk);
    d8 = 8'h01; pen = 0; ptype = 0; s2 = 0; div8 = 16'd3; v8 = 1;
    push_frame(9'h001, 8, 1'b0, 1'b0, 1'b0, 3);
    @(negedge clk); v8 = 0; div8 = 16'd0;
    cyc = 0; busy_cyc = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (sbusy === 1'b1) busy_cyc++;
      checks++;
      if ({stx, sdone} !== {e, 1'b0}) begin
        failures++;
        $display("FAIL divider cyc=%0d got(tx,done)=%b exp=%b", cyc, {stx, sdone}, {e, 1'b0});
      end
      cyc++;
      @(negedge clk);
    end
    checks++;
    if (busy_cyc != 40 || sbusy !== 1'b0 || sdone !== 1'b1) begin
      failures++;
      $display("FAIL divider_len busy_cycles=%0d busy=%b done=%b exp 40/0/1", busy_cyc, sbusy, sdone);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic e;
    int cyc, done0;
    sel = 8; exp_q.delete();
    done0 = done8_cnt;
    @(negedge clk);
    d8 = 8'h5A; pen = 0; ptype = 0; s2 = 0; div8 = 16'd1; v8 = 1;
    push_frame(9'h05A, 8, 1'b0, 1'b0, 1'b0, 1);
    // v8 stays high across the whole first frame
    @(negedge clk);
    cyc = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({stx, sbusy, sdone} !== {e, 2'b10}) begin
        failures++;
        $display("FAIL b2b_first cyc=%0d got=%b exp=%b", cyc, {stx, sbusy, sdone}, {e, 2'b10});
      end
      if (cyc == 3) d8 = 8'hC3;
      cyc++;
      @(negedge clk);
    end
    // completion edge: request held but not accepted yet
    checks++;
    if ({stx, sbusy, sdone} !== 3'b101) begin
      failures++;
      $display("FAIL b2b_gap got=%b exp=101", {stx, sbusy, sdone});
    end
    push_frame(9'h0C3, 8, 1'b0, 1'b0, 1'b0, 1);
    @(negedge clk);
    v8 = 0;
    cyc = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({stx, sbusy, sdone} !== {e, 2'b10}) begin
        failures++;
        $display("FAIL b2b_second cyc=%0d got=%b exp=%b", cyc, {stx, sbusy, sdone}, {e, 2'b10});
      end
      cyc++;
      @(negedge clk);
    end
    checks++;
    if ({stx, sbusy, sdone} !== 3'b101) begin
      failures++;
      $display("FAIL b2b_done got=%b exp=101", {stx, sbusy, sdone});
    end
    @(negedge clk); @(negedge clk);
    checks++;
    if (done8_cnt - done0 != 2) begin
      failures++;
      $display("FAIL b2b_pulses got=%0d exp=2", done8_cnt - done0);
    end
  endtask

  task automatic test_midframe_reset;
    logic e;
    int cyc, done0;
    sel = 8; exp_q.delete();
    @(negedge clk);
    d8 = 8'h55; pen = 0; ptype = 0; s2 = 0; div8 = 16'd1; v8 = 1;
    @(negedge clk); v8 = 0;
    repeat (6) @(negedge clk);   // start bit done, now inside the data bits
    done0 = done8_cnt;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({tx8, busy8, done8} !== 3'b100) begin
      failures++;
      $display("FAIL async_reset got=%b exp=100", {tx8, busy8, done8});
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx8, busy8} !== 2'b10 || done8_cnt != done0) begin
      failures++;
      $display("FAIL reset_abort tx=%b busy=%b pulses=%0d exp 1/0/0", tx8, busy8, done8_cnt - done0);
    end
    d8 = 8'h3C; pen = 1; ptype = 0; s2 = 0; div8 = 16'd0; v8 = 1;
    push_frame(9'h03C, 8, 1'b1, 1'b0, 1'b0, 0);
    @(negedge clk); v8 = 0;
    cyc = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({stx, sbusy, sdone} !== {e, 2'b10}) begin
        failures++;
        $display("FAIL post_reset cyc=%0d got=%b exp=%b", cyc, {stx, sbusy, sdone}, {e, 2'b10});
      end
      cyc++;
      @(negedge clk);
    end
    checks++;
    if ({stx, sbusy, sdone} !== 3'b101) begin
      failures++;
      $display("FAIL post_reset_done got=%b exp=101", {stx, sbusy, sdone});
    end
    @(negedge clk);
  endtask

  task automatic test_widths;
    logic e;
    int cyc;
    for (int k = 0; k < 3; k++) begin
      exp_q.delete();
      @(negedge clk);
      case (k)
        0: begin
          sel = 5; d5 = 5'h15; div5 = 4'hF; pen = 1; ptype = 0; s2 = 0; v5 = 1;
          push_frame(9'h015, 5, 1'b1, 1'b0, 1'b0, 15);
        end
        1: begin
          sel = 9; d9 = 9'h1AB; div9 = 16'd0; pen = 1; ptype = 1; s2 = 1; v9 = 1;
          push_frame(9'h1AB, 9, 1'b1, 1'b1, 1'b1, 0);
        end
        default: begin
          sel = 9; d9 = 9'h0F0; div9 = 16'd2; pen = 0; ptype = 0; s2 = 0; v9 = 1;
          push_frame(9'h0F0, 9, 1'b0, 1'b0, 1'b0, 2);
        end
      endcase
      @(negedge clk); v5 = 0; v9 = 0;
      cyc = 0;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({stx, sbusy, sdone} !== {e, 2'b10}) begin
          failures++;
          $display("FAIL width k=%0d cyc=%0d got=%b exp=%b", k, cyc, {stx, sbusy, sdone}, {e, 2'b10});
        end
        cyc++;
        @(negedge clk);
      end
      checks++;
      if ({stx, sbusy, sdone} !== 3'b101) begin
        failures++;
        $display("FAIL width_done k=%0d got=%b exp=101", k, {stx, sbusy, sdone});
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_divider();
    test_back_to_back();
    test_midframe_reset();
    test_widths();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame_engine.md
# uart_tx_frame_engine

Parametrised UART transmitter: accepts one DATA_WIDTH-bit word per valid/busy handshake and serialises it LSB-first as a complete frame on a single line. The frame is start bit, data bits, optional even/odd parity, then 1 or 2 stop bits. A programmable baud divider sets the bit period. It sits between the APB register file (data, config) and the TX pin, replacing the fixed-format, one-bit-per-clock TX control path.

## Interface

- DATA_WIDTH, 8: data bits per frame; legal range 5..9.
- DIV_WIDTH, 16: width of the baud divider input and internal bit-period counter.
- UCLK  in  1  UART clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- tx_data  in  DATA_WIDTH  word to transmit; sampled only on the accept edge.
- data_valid  in  1  request to send tx_data.
- parity_en  in  1  1 = insert parity bit.
- parity_type  in  1  0 = even, 1 = odd.
- stop_2  in  1  0 = one stop bit, 1 = two stop bits.
- baud_div  in  DIV_WIDTH  bit period minus one, in UCLK cycles.
- tx_out  out  1  registered serial line; idles high.
- busy  out  1  registered; high from the accept edge until the frame completes.
- tx_done  out  1  registered one-cycle pulse marking frame completion.

## Operation

- Reset (asynchronous, active-low) forces: state IDLE, tx_out=1, busy=0, tx_done=0, and clears all counters and the shift register.
- Accept: a word is accepted on a rising edge where state=IDLE and data_valid=1.
  - At that edge, tx_data, parity_en, parity_type, stop_2 and baud_div are latched.
  - Later changes to these inputs do not affect the frame in flight.
- data_valid while busy=1 is ignored. The word is not queued; the requester must hold data_valid until busy=0.
- States:
  - IDLE -> START on accept.
  - START -> DATA.
  - DATA -> PARITY if the latched parity_en=1, otherwise DATA -> STOP.
  - PARITY -> STOP.
  - STOP -> IDLE after 1 or 2 stop bit periods, per the latched stop_2.
- Bit period: every transmitted bit lasts exactly baud_div_latched+1 cycles.
  - A DIV_WIDTH bit-period counter counts 0..baud_div_latched and wraps.
  - Advancing to the next bit, bit index or state happens only on the wrap edge.
- DATA state: the bit index runs 0..DATA_WIDTH-1 and tx_out = data[index] (LSB first). The index has $clog2(DATA_WIDTH) bits. Leaving DATA is decided on index = DATA_WIDTH-1 with the counter at wrap; the index never wraps.
- Parity bit = XOR of the latched data bits, inverted when parity_type=1.
- tx_out value per state: START = 0; PARITY = parity bit; STOP = 1; IDLE = 1.
- Frame length L = (1 + DATA_WIDTH + parity_en + 1 + stop_2) × (baud_div+1) cycles.
- Reset asserted mid-frame aborts the frame immediately: tx_out=1, busy=0, and no tx_done pulse is generated.

## Timing

- Accept edge T0: from T0, busy=1 and tx_out=0 (start bit).
- The start bit occupies cycles T0..T0+baud_div; the bits that follow are contiguous.
- Completion edge T0+L: state returns to IDLE, busy=0, tx_out stays 1, and tx_done=1 for exactly one cycle.
- Back-to-back frames:
  - data_valid=1 at the completion edge is not accepted, because state is still STOP before that edge.
  - A request present in the following cycle is accepted at edge T0+L+1, giving a minimum inter-frame idle of 1 cycle (tx_out=1).
- baud_div=0 gives one bit per UCLK cycle.
- baud_div = all-ones gives a period of 2^DIV_WIDTH cycles; the counter must not overflow.

## Test plan

- 8N1 frame: DATA_WIDTH=8, baud_div=0, tx_data=0xA5, parity_en=0, stop_2=0 -> tx_out over 10 cycles = 0,1,0,1,0,0,1,0,1,1; tx_done at T0+10.
- Parity: 0xA5 with even parity -> parity bit 0; with odd parity -> 1. 0x07 with even parity -> 1. With 2 stop bits, L = 12 cycles.
- Divider: baud_div=3 with 0x01 (8N1) -> each bit held exactly 4 cycles; L=40; busy high for 40 cycles.
- Handshake:
  - data_valid held through a frame, with tx_data changed mid-frame -> the in-flight frame is unchanged.
  - The second word is accepted at T0+L+1, and exactly one tx_done pulse occurs per frame.
- Reset mid-frame: assert reset during the DATA bits -> tx_out=1 and busy=0 immediately (asynchronously), no tx_done. After release, a new 0x3C frame transmits correctly.
- DATA_WIDTH=5 and DATA_WIDTH=9 builds: 0x15 (5-bit) and 0x1AB (9-bit) serialise LSB-first with the correct frame length and correct parity.
